// File: rtl/mem_arbiter.sv
// Two-port round-robin memory arbiter with combinational grant and 1-cycle read return.
// Define MEM_ARBITER_LOCK_EN to add per-port lock inputs and a lock-owner register.
module mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] i_rq0_addr,
  input  logic          i_rq0_rd,
  input  logic          i_rq0_wr,
  input  logic [DW-1:0] i_rq0_wrdata,
  output logic          o_rq0_waitreq,
  output logic [DW-1:0] o_rq0_rddata,
  output logic          o_rq0_rdvalid,
  input  logic [AW-1:0] i_rq1_addr,
  input  logic          i_rq1_rd,
  input  logic          i_rq1_wr,
  input  logic [DW-1:0] i_rq1_wrdata,
  output logic          o_rq1_waitreq,
  output logic [DW-1:0] o_rq1_rddata,
  output logic          o_rq1_rdvalid,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_rd,
  output logic          o_mem_wr,
  output logic [DW-1:0] o_mem_wrdata,
  input  logic [DW-1:0] i_mem_rddata
`ifdef MEM_ARBITER_LOCK_EN
  ,
  input  logic          i_rq0_lock,
  input  logic          i_rq1_lock
`endif
);

  logic act0, act1;
  logic allow0, allow1;
  logic req0, req1;
  logic gnt_vld, gnt_id;
  logic sel_wr, sel_rd;

  logic last_grant_q, last_grant_d;
  logic rd_pending_q, rd_pending_d;
  logic rd_port_q, rd_port_d;

  assign act0 = i_rq0_rd | i_rq0_wr;
  assign act1 = i_rq1_rd | i_rq1_wr;

`ifdef MEM_ARBITER_LOCK_EN
  logic lock_vld_q, lock_vld_d;
  logic lock_id_q, lock_id_d;
  logic win_lock, own_lock;

  // An owned lock masks the other port out of arbitration.
  assign allow0 = ~lock_vld_q | ~lock_id_q;
  assign allow1 = ~lock_vld_q | lock_id_q;

  always_comb begin
    lock_vld_d = lock_vld_q;
    lock_id_d  = lock_id_q;
    win_lock   = gnt_id ? i_rq1_lock : i_rq0_lock;
    own_lock   = lock_id_q ? i_rq1_lock : i_rq0_lock;
    if (gnt_vld && win_lock) begin
      lock_vld_d = 1'b1;
      lock_id_d  = gnt_id;
    end else if (lock_vld_q && !own_lock) begin
      lock_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_vld_q <= 1'b0;
      lock_id_q  <= 1'b0;
    end else begin
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
    end
  end
`else
  assign allow0 = 1'b1;
  assign allow1 = 1'b1;
`endif

  assign req0 = act0 & allow0;
  assign req1 = act1 & allow1;

  // last_grant = 1 means port 0 takes the next tie.
  always_comb begin
    gnt_vld = (req0 | req1) & reset_n;
    gnt_id  = 1'b0;
    unique case ({req1, req0})
      2'b11:   gnt_id = ~last_grant_q;
      2'b10:   gnt_id = 1'b1;
      default: gnt_id = 1'b0;
    endcase
  end

  always_comb begin
    o_mem_addr   = '0;
    o_mem_wrdata = '0;
    sel_wr       = 1'b0;
    sel_rd       = 1'b0;
    if (gnt_vld) begin
      o_mem_addr   = gnt_id ? i_rq1_addr : i_rq0_addr;
      o_mem_wrdata = gnt_id ? i_rq1_wrdata : i_rq0_wrdata;
      sel_wr       = gnt_id ? i_rq1_wr : i_rq0_wr;
      sel_rd       = (gnt_id ? i_rq1_rd : i_rq0_rd) & ~sel_wr;
    end
    o_mem_wr = sel_wr;
    o_mem_rd = sel_rd;
  end

  assign o_rq0_waitreq = act0 & ~(gnt_vld & ~gnt_id);
  assign o_rq1_waitreq = act1 & ~(gnt_vld & gnt_id);

  always_comb begin
    last_grant_d = gnt_vld ? gnt_id : last_grant_q;
    rd_pending_d = sel_rd;
    rd_port_d    = sel_rd ? gnt_id : rd_port_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
      rd_pending_q <= 1'b0;
      rd_port_q    <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rd_pending_q <= rd_pending_d;
      rd_port_q    <= rd_port_d;
    end
  end

  assign o_rq0_rdvalid = rd_pending_q & ~rd_port_q;
  assign o_rq1_rdvalid = rd_pending_q & rd_port_q;
  assign o_rq0_rddata  = o_rq0_rdvalid ? i_mem_rddata : '0;
  assign o_rq1_rddata  = o_rq1_rdvalid ? i_mem_rddata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, reset/stall sequences,
// and random traffic against a transaction-level reference model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] a0, a1, d0, d1;
  logic        rd0, wr0, rd1, wr1;
  logic        lock0, lock1;
  logic        w0, w1, v0, v1;
  logic [15:0] r0, r1;
  logic [15:0] maddr, mwd;
  logic        mrd, mwr;
  logic [15:0] mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(16), .DW(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_rq0_addr(a0), .i_rq0_rd(rd0), .i_rq0_wr(wr0), .i_rq0_wrdata(d0),
    .o_rq0_waitreq(w0), .o_rq0_rddata(r0), .o_rq0_rdvalid(v0),
    .i_rq1_addr(a1), .i_rq1_rd(rd1), .i_rq1_wr(wr1), .i_rq1_wrdata(d1),
    .o_rq1_waitreq(w1), .o_rq1_rddata(r1), .o_rq1_rdvalid(v1),
    .o_mem_addr(maddr), .o_mem_rd(mrd), .o_mem_wr(mwr),
    .o_mem_wrdata(mwd), .i_mem_rddata(mem_rdata)
`ifdef MEM_ARBITER_LOCK_EN
    , .i_rq0_lock(lock0), .i_rq1_lock(lock1)
`endif
  );

  // Memory behind the arbiter; unwritten words read as addr ^ 0x5A5A.
  logic [15:0] tbmem  [0:65535];
  logic [15:0] refmem [0:65535];
  logic [15:0] mem_rd_q;
  assign mem_rdata = mem_rd_q;

  always @(posedge clk) begin
    if (mwr) tbmem[maddr] <= mwd;
    if (mrd) mem_rd_q <= tbmem[maddr];
  end

  typedef struct {
    logic w0, w1, mrd, mwr;
    logic [15:0] maddr, mwd;
    logic v0, v1;
    logic [15:0] r0, r1;
  } exp_t;

  typedef struct {
    logic rst;
    logic rd0, wr0, rd1, wr1;
    logic [15:0] a0, d0, a1, d1;
    exp_t e;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string t, input exp_t e);
    chk1({t, " waitreq0"}, w0, e.w0);
    chk1({t, " waitreq1"}, w1, e.w1);
    chk1({t, " mem_rd"}, mrd, e.mrd);
    chk1({t, " mem_wr"}, mwr, e.mwr);
    chk({t, " mem_addr"}, maddr, e.maddr);
    chk({t, " mem_wrdata"}, mwd, e.mwd);
    chk1({t, " rdvalid0"}, v0, e.v0);
    chk1({t, " rdvalid1"}, v1, e.v1);
    chk({t, " rddata0"}, r0, e.r0);
    chk({t, " rddata1"}, r1, e.r1);
  endtask

  task automatic drive(input logic xrd0, input logic xwr0,
                       input logic [15:0] xa0, input logic [15:0] xd0,
                       input logic xrd1, input logic xwr1,
                       input logic [15:0] xa1, input logic [15:0] xd1);
    rd0 = xrd0; wr0 = xwr0; a0 = xa0; d0 = xd0;
    rd1 = xrd1; wr1 = xwr1; a1 = xa1; d1 = xd1;
  endtask

  task automatic idle();
    drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    lock0 = 1'b0;
    lock1 = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic rst, input logic [3:0] cmd,
                              input logic [15:0] xa0, input logic [15:0] xd0,
                              input logic [15:0] xa1, input logic [15:0] xd1,
                              input logic [3:0] ewm,
                              input logic [15:0] ea, input logic [15:0] ed,
                              input logic [1:0] ev,
                              input logic [15:0] er0, input logic [15:0] er1);
    vec_t v;
    v.rst = rst;
    {v.rd0, v.wr0, v.rd1, v.wr1} = cmd;
    v.a0 = xa0; v.d0 = xd0; v.a1 = xa1; v.d1 = xd1;
    {v.e.w0, v.e.w1, v.e.mrd, v.e.mwr} = ewm;
    v.e.maddr = ea; v.e.mwd = ed;
    {v.e.v0, v.e.v1} = ev;
    v.e.r0 = er0; v.e.r1 = er1;
    return v;
  endfunction

  vec_t tbl [10];

  int          ref_last;
  int          ref_pend;
  logic [15:0] ref_pdata;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int stalls, wr_count;
    logic p1_done;
    for (int i = 0; i < 65536; i++) begin
      tbmem[i]  = 16'(i) ^ 16'h5A5A;
      refmem[i] = 16'(i) ^ 16'h5A5A;
    end

    // reset state, with port 0 requesting
    idle();
    reset_n = 1'b0;
    rd0 = 1'b1;
    @(negedge clk);
    chk1("rst mem_rd", mrd, 1'b0);
    chk1("rst mem_wr", mwr, 1'b0);
    chk1("rst rdvalid0", v0, 1'b0);
    chk1("rst rdvalid1", v1, 1'b0);
    do_reset();

    // write/read, rd+wr collapse, then alternating reads after reset
    tbl[0] = mk(0, 4'b0100, 16'h0010, 16'hBEEF, 0, 0, 4'b0001,
                16'h0010, 16'hBEEF, 2'b00, 0, 0);
    tbl[1] = mk(0, 4'b1000, 16'h0010, 0, 0, 0, 4'b0010,
                16'h0010, 0, 2'b00, 0, 0);
    tbl[2] = mk(0, 4'b0000, 0, 0, 0, 0, 4'b0000,
                0, 0, 2'b10, 16'hBEEF, 0);
    tbl[3] = mk(0, 4'b1100, 16'h0020, 16'h1234, 0, 0, 4'b0001,
                16'h0020, 16'h1234, 2'b00, 0, 0);
    tbl[4] = mk(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 2'b00, 0, 0);
    tbl[5] = mk(1, 4'b1010, 16'h0000, 0, 16'h0100, 0, 4'b0110,
                16'h0000, 0, 2'b00, 0, 0);
    tbl[6] = mk(0, 4'b1010, 16'h0000, 0, 16'h0100, 0, 4'b1010,
                16'h0100, 0, 2'b10, 16'h5A5A, 0);
    tbl[7] = mk(0, 4'b1010, 16'h0000, 0, 16'h0100, 0, 4'b0110,
                16'h0000, 0, 2'b01, 0, 16'h5B5A);
    tbl[8] = mk(0, 4'b1010, 16'h0000, 0, 16'h0100, 0, 4'b1010,
                16'h0100, 0, 2'b10, 16'h5A5A, 0);
    tbl[9] = mk(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 2'b01, 0, 16'h5B5A);

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].rst) do_reset();
      drive(tbl[i].rd0, tbl[i].wr0, tbl[i].a0, tbl[i].d0,
            tbl[i].rd1, tbl[i].wr1, tbl[i].a1, tbl[i].d1);
      @(negedge clk);
      chk_outs($sformatf("vec%0d", i), tbl[i].e);
      @(posedge clk);
      #1;
    end

    // read outstanding when reset hits is discarded
    do_reset();
    drive(0, 0, 0, 0, 1, 0, 16'h0100, 0);
    @(negedge clk);
    chk1("rstrd grant1", w1, 1'b0);
    chk1("rstrd mem_rd", mrd, 1'b1);
    @(posedge clk);
    #1 reset_n = 1'b0;
    idle();
    #1;
    chk1("rstrd rdvalid0", v0, 1'b0);
    chk1("rstrd rdvalid1", v1, 1'b0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    drive(1, 0, 16'h0000, 0, 1, 0, 16'h0100, 0);
    @(negedge clk);
    chk1("rstrd tie waitreq0", w0, 1'b0);
    chk1("rstrd tie waitreq1", w1, 1'b1);
    chk1("rstrd post rdvalid1", v1, 1'b0);
    chk1("rstrd post rdvalid0", v0, 1'b0);
    @(posedge clk);
    #1 idle();
    @(negedge clk);
    chk1("rstrd p0 rdvalid", v0, 1'b1);
    chk("rstrd p0 rddata", r0, 16'h5A5A);
    chk1("rstrd p1 quiet", v1, 1'b0);
    @(posedge clk);
    #1;

    // port 1 write held while port 0 wins, then accepted once
    do_reset();
    stalls = 0;
    wr_count = 0;
    p1_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 16'h0000, 0, 0, !p1_done, 16'h0200, 16'hCAFE);
      @(negedge clk);
      if (mwr && maddr == 16'h0200) begin
        wr_count++;
        chk("stall wrdata", mwd, 16'hCAFE);
      end
      if (wr1) begin
        if (w1) stalls++;
        else p1_done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    chk1("stall accepted", p1_done, 1'b1);
    chk("stall cycles", 16'(stalls), 16'd1);
    chk("stall write count", 16'(wr_count), 16'd1);

`ifdef MEM_ARBITER_LOCK_EN
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 16'h0000, 0, 1, 0, 16'h0100, 0);
      lock0 = 1'b1;
      @(negedge clk);
      chk1($sformatf("lock%0d waitreq0", i), w0, 1'b0);
      chk1($sformatf("lock%0d waitreq1", i), w1, 1'b1);
      @(posedge clk);
      #1;
    end
    drive(0, 0, 0, 0, 1, 0, 16'h0100, 0);
    lock0 = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk1("unlock waitreq1", w1, 1'b0);
    chk("unlock addr", maddr, 16'h0100);
    @(posedge clk);
    #1;
`endif

    // random traffic against the reference model
    do_reset();
    ref_last = 1;
    ref_pend = -1;
    ref_pdata = '0;
    for (int n = 0; n < 400; n++) begin
      exp_t e;
      int   win;
      logic iswr;
      logic [15:0] wa, wd;
      logic [1:0] c0, c1;
      c0 = 2'($urandom_range(0, 3));
      c1 = 2'($urandom_range(0, 3));
      drive(c0[1], c0[0], 16'h8000 | 16'($urandom_range(0, 7) * 2),
            16'($urandom),
            c1[1], c1[0], 16'h8000 | 16'($urandom_range(0, 7) * 2),
            16'($urandom));
      win = -1;
      if ((rd0 || wr0) && (rd1 || wr1)) win = 1 - ref_last;
      else if (rd0 || wr0) win = 0;
      else if (rd1 || wr1) win = 1;
      iswr = (win == 0) ? wr0 : (win == 1) ? wr1 : 1'b0;
      wa = (win == 0) ? a0 : (win == 1) ? a1 : 16'h0;
      wd = (win == 0) ? d0 : (win == 1) ? d1 : 16'h0;
      e.w0 = (rd0 || wr0) && win != 0;
      e.w1 = (rd1 || wr1) && win != 1;
      e.mwr = (win >= 0) && iswr;
      e.mrd = (win >= 0) && !iswr;
      e.maddr = wa;
      e.mwd = wd;
      e.v0 = (ref_pend == 0);
      e.v1 = (ref_pend == 1);
      e.r0 = (ref_pend == 0) ? ref_pdata : 16'h0;
      e.r1 = (ref_pend == 1) ? ref_pdata : 16'h0;
      @(negedge clk);
      chk_outs($sformatf("rnd%0d", n), e);
      ref_pend = -1;
      if (win >= 0) begin
        ref_last = win;
        if (iswr) begin
          refmem[wa] = wd;
        end else begin
          ref_pend = win;
          ref_pdata = refmem[wa];
        end
      end
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: AW, 16, address width in bits (byte address).
REQ-002 Parameter: DW, 16, data width in bits.
REQ-003 The block SHALL have one clock, clk; reset is asynchronous and active-low, named reset_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 i_rq0_addr / i_rq1_addr  input  AW  requester byte address.
REQ-007 i_rq0_rd / i_rq1_rd  input  1  read request.
REQ-008 i_rq0_wr / i_rq1_wr  input  1  write request.
REQ-009 i_rq0_wrdata / i_rq1_wrdata  input  DW  write data.
REQ-010 o_rq0_waitreq / o_rq1_waitreq  output  1  command not accepted this cycle; requester holds it.
REQ-011 o_rq0_rddata / o_rq1_rddata  output  DW  read return data.
REQ-012 o_rq0_rdvalid / o_rq1_rdvalid  output  1  rddata valid this cycle.
REQ-013 o_mem_addr  output  AW; o_mem_rd  output  1; o_mem_wr  output  1; o_mem_wrdata  output  DW: shared memory command.
REQ-014 i_mem_rddata  input  DW  memory read data, valid one cycle after o_mem_rd.

Function
REQ-015 Request N SHALL be active when i_rqN_rd or i_rqN_wr is 1; if both are 1, SHALL be treated as a write only.
REQ-016 Grant SHALL be combinational in the request cycle: a single active requester wins; if both are active, the requester not granted most recently wins (round-robin pointer last_grant).
REQ-017 Winner's addr/wrdata/rd/wr SHALL be driven to the memory in the same cycle; its waitreq = 0; an active loser's waitreq = 1; an idle requester's waitreq = 0.
REQ-018 With no active request: o_mem_rd = o_mem_wr = 0, o_mem_addr = 0, o_mem_wrdata = 0.
REQ-019 last_grant SHALL update to the winner on every clock edge on which a grant occurs; it SHALL hold otherwise.
REQ-020 A granted read SHALL set rd_pending = 1 and rd_port = winner for exactly one cycle.
REQ-021 In the cycle after a granted read, o_rqX_rdvalid = 1 for X = rd_port only, with o_rqX_rddata = i_mem_rddata (combinational pass-through); read latency is exactly 1 cycle.
REQ-022 o_rqN_rddata SHALL be 0 whenever o_rqN_rdvalid = 0.
REQ-023 Back-to-back grants (read then read or write, either port, every cycle) SHALL be supported with no bubble; a read return and a new grant in the same cycle are independent.
REQ-024 Both ports SHALL never have waitreq = 0 together while both are active.

Reset
REQ-025 While reset_n = 0: last_grant = 1 (port 0 wins the first tie), rd_pending = 0, lock state cleared, all rdvalid = 0, memory rd/wr = 0.
REQ-026 Reset asserted with a read outstanding SHALL discard it; no rdvalid SHALL follow reset release.

Configuration
REQ-027 Macro MEM_ARBITER_LOCK_EN, when defined, SHALL add inputs i_rq0_lock / i_rq1_lock (1 bit each) and a lock-owner register.
REQ-028 With it defined: a grant with the winner's lock = 1 SHALL make that requester lock owner; while owned, only the owner may be granted (other port waitreq = 1 if active); ownership SHALL clear on the first edge where the owner's lock = 0.
REQ-029 Without it: no lock ports, pure round-robin per REQ-016.

Verification
REQ-030 Port 0 alone writes 0xBEEF to 0x0010, then reads 0x0010 -> o_mem_wr on cycle 1, o_rq0_rdvalid with 0xBEEF on cycle 3, o_rq1_rdvalid stays 0.
REQ-031 After reset, both ports read every cycle (0x0000, 0x0100) -> grants alternate 0,1,0,1; each rdvalid on its own port, one cycle after its grant, data correct.
REQ-032 Port 1 read granted, reset_n pulsed low the next cycle -> no rdvalid on either port; after release, port 0 wins the first tie.
REQ-033 Port 0 with rd = wr = 1, addr 0x0020, data 0x1234 -> memory sees write only; no rdvalid.
REQ-034 LOCK_EN: port 0 holds lock for 3 grants while port 1 requests -> port 1 waitreq = 1 for those 3 cycles, granted the cycle after lock drops.
REQ-035 Port 1 writes stalled while port 0 wins -> port 1 command held stable, then accepted exactly once.
